// File: rtl/md5_crack_scheduler.sv
// md5_crack_scheduler: drives a lowercase brute-force keyspace into an MD5
// pipeline one guess per clock. A valid/guess delay line tracks each guess
// through the pipeline and compares the returned digest against the target.
// Optional macro MD5_SCHED_PERF_COUNTER_EN enables the 48-bit guess_count
// counter; without it guess_count is tied to zero.
module md5_crack_scheduler #(
    parameter int         PIPE_LATENCY = 64,
    parameter logic [7:0] CHAR_LO      = 8'h61,
    parameter logic [7:0] CHAR_HI      = 8'h7a
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   start_len,
    input  logic [3:0]   max_len,
    input  logic [31:0]  target_a,
    input  logic [31:0]  target_b,
    input  logic [31:0]  target_c,
    input  logic [31:0]  target_d,
    output logic [127:0] guess,
    output logic [3:0]   guesslen,
    input  logic [31:0]  hashA,
    input  logic [31:0]  hashB,
    input  logic [31:0]  hashC,
    input  logic [31:0]  hashD,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [127:0] found_guess,
    output logic [3:0]   found_len,
    output logic [47:0]  guess_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic [127:0]            target;
    logic [3:0]              last_len;
    logic [127:0]            odo;
    logic [3:0]              odo_len;
    logic [127:0]            odo_nxt;
    logic [3:0]              odo_len_nxt;
    logic                    odo_last;
    logic                    guess_vld;
    logic [PIPE_LATENCY-1:0] dl_vld;
    logic [127:0]            dl_guess [PIPE_LATENCY];
    logic [3:0]              dl_len   [PIPE_LATENCY];
    logic [PIPE_LATENCY-1:0] dl_rest;
    logic                    out_vld;
    logic                    hit;
    logic                    pending;
    logic                    active;

    // All-CHAR_LO odometer of the given length (minus one); unused bytes stay 0
    function automatic logic [127:0] lo_fill(input logic [3:0] len);
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) begin
            if (i <= int'(len)) f[127-8*i -: 8] = CHAR_LO;
        end
        return f;
    endfunction

    // Odometer step: last char fastest, CHAR_HI wraps with carry, carry out of char 0 grows length
    always_comb begin
        logic carry;
        carry       = 1'b1;
        odo_nxt     = odo;
        odo_len_nxt = odo_len;
        for (int i = 15; i >= 0; i--) begin
            if (carry && (i <= int'(odo_len))) begin
                if (odo[127-8*i -: 8] == CHAR_HI) begin
                    odo_nxt[127-8*i -: 8] = CHAR_LO;
                end else begin
                    odo_nxt[127-8*i -: 8] = odo[127-8*i -: 8] + 8'd1;
                    carry = 1'b0;
                end
            end
        end
        odo_last = carry && (odo_len == last_len);
        if (carry) begin
            odo_len_nxt = odo_len + 4'd1;
            odo_nxt     = lo_fill(odo_len + 4'd1);
        end
    end

    // Compare at the delay-line output; pending ignores the entry being consumed now
    always_comb begin
        dl_rest = dl_vld;
        dl_rest[PIPE_LATENCY-1] = 1'b0;
        pending = guess_vld || (|dl_rest);
        out_vld = dl_vld[PIPE_LATENCY-1];
        active  = (state == RUN) || (state == DRAIN);
        hit     = active && out_vld && ({hashA, hashB, hashC, hashD} == target);
    end

    // Search datapath: latch targets and odometer on start, step odometer in RUN, shift guess history
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            target   <= {target_a, target_b, target_c, target_d};
            last_len <= (max_len < start_len) ? start_len : max_len;
            odo      <= lo_fill(start_len);
            odo_len  <= start_len;
        end else if (state == RUN) begin
            odo      <= odo_nxt;
            odo_len  <= odo_len_nxt;
        end
        dl_guess[0] <= guess;
        dl_len[0]   <= guesslen;
        for (int i = 1; i < PIPE_LATENCY; i++) begin
            dl_guess[i] <= dl_guess[i-1];
            dl_len[i]   <= dl_len[i-1];
        end
    end

    // Control FSM: issue, drain, report; a match aborts the search and flushes in-flight guesses
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            guess       <= '0;
            guesslen    <= '0;
            guess_vld   <= 1'b0;
            dl_vld      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_guess <= '0;
            found_len   <= '0;
        end else begin
            done   <= 1'b0;
            dl_vld <= {dl_vld[PIPE_LATENCY-2:0], guess_vld};
            case (state)
                IDLE: begin
                    guess     <= '0;
                    guesslen  <= '0;
                    guess_vld <= 1'b0;
                    if (start) begin
                        found       <= 1'b0;
                        found_guess <= '0;
                        found_len   <= '0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    guess     <= odo;
                    guesslen  <= odo_len;
                    guess_vld <= 1'b1;
                    if (odo_last) state <= DRAIN;
                end
                DRAIN: begin
                    guess     <= '0;
                    guesslen  <= '0;
                    guess_vld <= 1'b0;
                    if (!pending) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    guess     <= '0;
                    guesslen  <= '0;
                    guess_vld <= 1'b0;
                    state     <= IDLE;
                end
            endcase
            if (hit) begin
                found       <= 1'b1;
                found_guess <= dl_guess[PIPE_LATENCY-1];
                found_len   <= dl_len[PIPE_LATENCY-1];
                state       <= DONE;
                busy        <= 1'b0;
                done        <= 1'b1;
                guess       <= '0;
                guesslen    <= '0;
                guess_vld   <= 1'b0;
                dl_vld      <= '0;
            end
        end
    end

`ifdef MD5_SCHED_PERF_COUNTER_EN
    // Count every guess whose digest reaches the comparator, including a matching one
    always_ff @(posedge clk) begin
        if (reset) begin
            guess_count <= '0;
        end else if (state == IDLE && start) begin
            guess_count <= '0;
        end else if (active && out_vld) begin
            guess_count <= guess_count + 48'd1;
        end
    end
`else
    assign guess_count = '0;
`endif

endmodule

// File: tb/tb_md5_crack_scheduler.sv
// Bench for md5_crack_scheduler. A stand-in pipeline returns a reversible
// digest of each guess exactly PIPE_LATENCY cycles after it was presented.
module tb_md5_crack_scheduler;

    localparam int LAT = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   start_len;
    logic [3:0]   max_len;
    logic [31:0]  target_a, target_b, target_c, target_d;
    logic [127:0] guess;
    logic [3:0]   guesslen;
    logic [31:0]  hashA, hashB, hashC, hashD;
    logic         busy, done, found;
    logic [127:0] found_guess;
    logic [3:0]   found_len;
    logic [47:0]  guess_count;

    int total = 0;
    int bad   = 0;

    logic [127:0] rec_g [$];
    logic [3:0]   rec_l [$];
    int           done_at;
    int           done_cnt;
    bit           timed_out;

    logic [127:0] pipe [LAT];

    always #5 clk = ~clk;

    md5_crack_scheduler #(.PIPE_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .start_len(start_len), .max_len(max_len),
        .target_a(target_a), .target_b(target_b), .target_c(target_c), .target_d(target_d),
        .guess(guess), .guesslen(guesslen),
        .hashA(hashA), .hashB(hashB), .hashC(hashC), .hashD(hashD),
        .busy(busy), .done(done), .found(found),
        .found_guess(found_guess), .found_len(found_len),
        .guess_count(guess_count)
    );

    // Injective stand-in for the MD5 digest of (guess, length)
    function automatic logic [127:0] mock_hash(input logic [127:0] g, input logic [3:0] l);
        return g ^ {96'h0, l, 28'h0} ^ 128'hdeadbeef_0badf00d_12345678_9abcdef0;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= mock_hash(guess, guesslen);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {hashA, hashB, hashC, hashD} = pipe[LAT-1];

    function automatic longint pow26(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 26;
        return p;
    endfunction

    // Plaintext of `len` chars whose base-26 value is v (first char most significant)
    function automatic logic [127:0] val_guess(input int len, input longint v);
        logic [127:0] g = '0;
        for (int pos = len - 1; pos >= 0; pos--) begin
            g[127-8*pos -: 8] = 8'h61 + 8'(v % 26);
            v = v / 26;
        end
        return g;
    endfunction

    // k-th guess of a search over lengths s+1 .. e+1
    task automatic model_guess(input int s, input int e, input longint k,
                               output logic [127:0] g, output logic [3:0] l);
        int len = s + 1;
        while (len <= e + 1 && k >= pow26(len)) begin
            k = k - pow26(len);
            len++;
        end
        g = val_guess(len, k);
        l = 4'(len - 1);
    endtask

    function automatic logic [47:0] exp_count(input longint n);
`ifdef MD5_SCHED_PERF_COUNTER_EN
        return 48'(n);
`else
        return 48'(n * 0);
`endif
    endfunction

    task automatic run_search(input logic [3:0] s, input logic [3:0] m, input logic [127:0] tgt,
                              input int budget, input int restart_at);
        rec_g.delete();
        rec_l.delete();
        done_at   = -1;
        done_cnt  = 0;
        timed_out = 0;
        @(negedge clk);
        start = 1'b1; start_len = s; max_len = m;
        {target_a, target_b, target_c, target_d} = tgt;
        @(negedge clk);
        start = 1'b0;
        for (int cnt = 0; ; cnt++) begin
            if (guess !== '0) begin
                rec_g.push_back(guess);
                rec_l.push_back(guesslen);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = cnt;
            end else if (done_at >= 0) begin
                break;
            end
            if (cnt >= budget) begin
                timed_out = 1;
                break;
            end
            if (cnt == restart_at) begin
                start = 1'b1; start_len = 4'd2; max_len = 4'd2;
                {target_a, target_b, target_c, target_d} = ~tgt;
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_len = '0; max_len = '0;
        {target_a, target_b, target_c, target_d} = '0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0) begin bad++;
            $display("FAIL reset_flags busy=%b done=%b found=%b want 000", busy, done, found); end
        total++; if (guess !== '0 || guesslen !== '0) begin bad++;
            $display("FAIL reset_guess got %h/%0d want 0/0", guess, guesslen); end
        total++; if (found_guess !== '0 || found_len !== '0 || guess_count !== '0) begin bad++;
            $display("FAIL reset_result got %h/%0d/%0d want 0", found_guess, found_len, guess_count); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abc();
        logic [127:0] pt = {8'h61, 8'h62, 8'h63, 104'h0};
        run_search(4'd0, 4'd2, mock_hash(pt, 4'd2), 3000, -1);
        total++; if (timed_out) begin bad++; $display("FAIL abc_timeout got no done want done"); end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL abc_found got %b want 1", found); end
        total++; if (found_guess !== pt) begin bad++;
            $display("FAIL abc_guess got %h want %h", found_guess, pt); end
        total++; if (found_len !== 4'd2) begin bad++; $display("FAIL abc_len got %0d want 2", found_len); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL abc_done_width got %0d want 1", done_cnt); end
        total++; if (guess_count !== exp_count(731)) begin bad++;
            $display("FAIL abc_count got %0d want %0d", guess_count, exp_count(731)); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abc_busy got %b want 0", busy); end
    endtask

    task automatic test_exhaust();
        int mism = 0;
        logic [127:0] g;
        logic [3:0]   l;
        run_search(4'd0, 4'd0, mock_hash({8'hff, 120'h0}, 4'd0), 500, -1);
        total++; if (timed_out) begin bad++; $display("FAIL exh_timeout got no done want done"); end
        total++; if (rec_g.size() != 26) begin bad++;
            $display("FAIL exh_issued got %0d want 26", rec_g.size()); end
        for (int k = 0; k < rec_g.size() && k < 26; k++) begin
            model_guess(0, 0, k, g, l);
            if (rec_g[k] !== g || rec_l[k] !== l) mism++;
        end
        total++; if (mism != 0) begin bad++; $display("FAIL exh_sequence got %0d wrong want 0", mism); end
        total++; if (done_at < 26 + LAT || done_at > 28 + LAT) begin bad++;
            $display("FAIL exh_done_cycle got %0d want %0d..%0d", done_at, 26 + LAT, 28 + LAT); end
        total++; if (found !== 1'b0) begin bad++; $display("FAIL exh_found got %b want 0", found); end
        total++; if (guess_count !== exp_count(26)) begin bad++;
            $display("FAIL exh_count got %0d want %0d", guess_count, exp_count(26)); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL exh_done_width got %0d want 1", done_cnt); end
    endtask

    task automatic test_abcd();
        logic [127:0] pt = {8'h61, 8'h62, 8'h63, 8'h64, 96'h0};
        int badlen = 0;
        run_search(4'd3, 4'd3, mock_hash(pt, 4'd3), 3000, -1);
        total++; if (timed_out) begin bad++; $display("FAIL abcd_timeout got no done want done"); end
        total++; if (found !== 1'b1 || found_guess !== pt) begin bad++;
            $display("FAIL abcd_guess got %b/%h want 1/%h", found, found_guess, pt); end
        total++; if (found_len !== 4'd3) begin bad++; $display("FAIL abcd_len got %0d want 3", found_len); end
        foreach (rec_l[k]) if (rec_l[k] !== 4'd3) badlen++;
        total++; if (badlen != 0 || rec_l.size() < 732) begin bad++;
            $display("FAIL abcd_guesslen got %0d off-length of %0d want 0 of >=732", badlen, rec_l.size()); end
        total++; if (guess_count !== exp_count(732)) begin bad++;
            $display("FAIL abcd_count got %0d want %0d", guess_count, exp_count(732)); end
    endtask

    task automatic test_carry();
        logic [127:0] az  = {8'h61, 8'h7a, 112'h0};
        logic [127:0] ba  = {8'h62, 8'h61, 112'h0};
        logic [127:0] zz  = {8'h7a, 8'h7a, 112'h0};
        logic [127:0] aaa = {8'h61, 8'h61, 8'h61, 104'h0};
        run_search(4'd1, 4'd2, mock_hash({8'h61, 8'h61, 8'h62, 104'h0}, 4'd2), 3000, -1);
        total++; if (timed_out || rec_g.size() < 677) begin bad++;
            $display("FAIL carry_issued got %0d want >=677", rec_g.size()); end
        else begin
            total++; if (rec_g[25] !== az || rec_g[26] !== ba) begin bad++;
                $display("FAIL carry_az_ba got %h,%h want %h,%h", rec_g[25], rec_g[26], az, ba); end
            total++; if (rec_g[675] !== zz || rec_g[676] !== aaa) begin bad++;
                $display("FAIL carry_zz_aaa got %h,%h want %h,%h", rec_g[675], rec_g[676], zz, aaa); end
            total++; if (rec_l[675] !== 4'd1 || rec_l[676] !== 4'd2) begin bad++;
                $display("FAIL carry_len got %0d,%0d want 1,2", rec_l[675], rec_l[676]); end
        end
        total++; if (guess_count !== exp_count(678)) begin bad++;
            $display("FAIL carry_count got %0d want %0d", guess_count, exp_count(678)); end
    endtask

    task automatic test_reset_mid();
        int seen_done = 0, seen_found = 0;
        @(negedge clk);
        start = 1'b1; start_len = 4'd0; max_len = 4'd2;
        {target_a, target_b, target_c, target_d} = mock_hash({8'h61, 120'h0}, 4'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (busy !== 1'b0 || found !== 1'b0) begin bad++;
            $display("FAIL rstmid_flags got busy=%b found=%b want 0 0", busy, found); end
        total++; if (guess !== '0 || guesslen !== '0) begin bad++;
            $display("FAIL rstmid_guess got %h/%0d want 0/0", guess, guesslen); end
        repeat (LAT + 20) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
            if (found === 1'b1) seen_found++;
        end
        total++; if (seen_done != 0) begin bad++; $display("FAIL rstmid_done got %0d pulses want 0", seen_done); end
        total++; if (seen_found != 0) begin bad++; $display("FAIL rstmid_found got %0d want 0", seen_found); end
    endtask

    task automatic test_restart();
        logic [127:0] pt = {8'h61, 8'h62, 8'h63, 104'h0};
        run_search(4'd0, 4'd2, mock_hash(pt, 4'd2), 3000, 5);
        total++; if (timed_out || found !== 1'b1 || found_guess !== pt) begin bad++;
            $display("FAIL restart_guess got %b/%h want 1/%h", found, found_guess, pt); end
        total++; if (found_len !== 4'd2) begin bad++; $display("FAIL restart_len got %0d want 2", found_len); end
        total++; if (guess_count !== exp_count(731)) begin bad++;
            $display("FAIL restart_count got %0d want %0d", guess_count, exp_count(731)); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            int s, m, e, tl, mism;
            longint v, n;
            logic [127:0] pt, g;
            logic [3:0]   l;
            s  = $urandom_range(0, 1);
            m  = $urandom_range(0, 1);
            e  = (m < s) ? s : m;
            tl = $urandom_range(s + 1, e + 1);
            v  = longint'($urandom_range(0, 32'(pow26(tl) - 1)));
            pt = val_guess(tl, v);
            n  = v + 1;
            for (int len = s + 1; len < tl; len++) n = n + pow26(len);
            run_search(4'(s), 4'(m), mock_hash(pt, 4'(tl - 1)), 3000, -1);
            total++; if (timed_out || found !== 1'b1 || found_guess !== pt || found_len !== 4'(tl - 1)) begin bad++;
                $display("FAIL rand%0d_match got %b/%h/%0d want 1/%h/%0d", it, found, found_guess, found_len, pt, tl - 1); end
            total++; if (guess_count !== exp_count(n)) begin bad++;
                $display("FAIL rand%0d_count got %0d want %0d", it, guess_count, exp_count(n)); end
            mism = 0;
            for (longint k = 0; k < n; k++) begin
                model_guess(s, e, k, g, l);
                if (k >= rec_g.size() || rec_g[k] !== g || rec_l[k] !== l) mism++;
            end
            total++; if (mism != 0 || done_cnt != 1) begin bad++;
                $display("FAIL rand%0d_stream got %0d wrong, %0d done want 0, 1", it, mism, done_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_exhaust();
        test_abcd();
        test_carry();
        test_reset_mid();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md5_crack_scheduler.md
Name: md5_crack_scheduler

Overview:
- Sequences the MD5 pipeline for brute-force search.
- Enumerates a lowercase keyspace (a..z) from a start length to a max length and issues one guess per clock into the pipeline.
- Tracks each guess through the pipeline latency with a valid/guess delay line and compares the returned digest against a target.
- Reports the first matching plaintext, or exhaustion of the keyspace.

Parameters:
- PIPE_LATENCY, 64: cycles from guess/guesslen presented to the matching hashA..D output; delay line depth.
- CHAR_LO, 8'h61: first charset byte ('a').
- CHAR_HI, 8'h7a: last charset byte ('z').

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a search; ignored unless IDLE.
- start_len  in  4  first guess length minus 1 (0 = 1 char).
- max_len  in  4  last guess length minus 1; must be >= start_len.
- target_a  in  32  expected hashA.
- target_b  in  32  expected hashB.
- target_c  in  32  expected hashC.
- target_d  in  32  expected hashD.
- guess  out  128  to pipeline; char 0 at [127:120], unused bytes 0.
- guesslen  out  4  to pipeline; length minus 1.
- hashA  in  32  pipeline digest word A.
- hashB  in  32  pipeline digest word B.
- hashC  in  32  pipeline digest word C.
- hashD  in  32  pipeline digest word D.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when the search ends.
- found  out  1  sticky match flag.
- found_guess  out  128  matching plaintext, same packing as guess.
- found_len  out  4  matching length minus 1.
- guess_count  out  48  count of guesses whose digests were compared.

Behaviour:
- Reset values:
  - state = IDLE.
  - guess, guesslen, busy, done, found, found_guess, found_len, guess_count = 0.
  - Delay-line valid bits all 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches targets, start_len and max_len.
  - Odometer set to all-CHAR_LO at length start_len+1.
  - Clears found, found_guess, found_len and guess_count.
  - Next state RUN.
- RUN:
  - Each cycle, drive guess/guesslen from the odometer and push {valid=1, guess, len} into the delay line.
  - Last character increments fastest. CHAR_HI wraps to CHAR_LO and carries left.
  - Carry out of char 0 increments the length and resets all chars to CHAR_LO.
  - If the issued guess was the last one (length max_len+1, all CHAR_HI), next state is DRAIN.
- DRAIN: push valid=0 each cycle; when no valid bit remains in the delay line, next state DONE.
- Compare (RUN and DRAIN):
  - When the delay-line output valid=1, guess_count increments.
  - If {hashA,hashB,hashC,hashD} == the targets: found=1, capture found_guess/found_len from the delay-line output, next state DONE.
  - In-flight guesses are discarded.
  - guess_count includes the matching guess.
- DONE: done=1 for exactly one cycle; next state IDLE. found and found_guess are held until the next start.
- Pipeline interface:
  - Guess output changes every cycle in RUN.
  - In IDLE, DRAIN and DONE, guess and guesslen hold 0.
  - Delay line is aligned so its output pairs with the hash from PIPE_LATENCY cycles earlier.
- Boundaries:
  - start_len == max_len: a single-length search of 26^(len) guesses.
  - max_len < start_len: treated as max_len = start_len.
  - Match on the very last guess: found=1 and DONE, with no separate exhausted signal.
  - start during RUN, DRAIN or DONE is ignored.
  - reset mid-search returns to IDLE within one cycle, clearing valid bits so stale pipeline outputs never match.
  - Lengths are limited to 16 chars by the 4-bit encoding.

Optional Feature:
- MD5_SCHED_PERF_COUNTER_EN:
  - Defined: guess_count implemented as a 48-bit counter as above.
  - Undefined: guess_count tied to 0, and the counter logic is not generated.

Test Plan:
- reset, start, start_len=0, max_len=2, target = MD5("abc") = 900150983cd24fb0d6963f7d28e17f72 (word order as the pipeline emits) -> found=1, found_guess=128'h61626300..., found_len=2, done pulse, guess_count=731 (with macro).
- start_len=0, max_len=0, unreachable target -> exactly 26 issued guesses "a".."z", done at cycle 26+PIPE_LATENCY+1 after start (±1 per state), found=0, guess_count=26.
- start_len=3, max_len=3, target = MD5("abcd") -> found_guess=128'h61626364..., found_len=3, guesslen driven as 3 throughout.
- Carry check: start_len=1; observe guesses "az" -> "ba" and "zz" -> "aaa" (guesslen 1 -> 2) on consecutive cycles.
- reset asserted 10 cycles into RUN with a target that the next drained output would match -> busy=0, found=0, guess and guesslen=0; no done pulse.
- start pulsed again during RUN -> ignored; search result identical to scenario 1.
